audio_recorder: RTL and testbench
=================================

Name: audio_recorder

Overview:
- Capture side of the trumpet practice audio path. Drains mic samples from Audio_Controller through the audio_in_available / read_audio_in handshake.
- Truncates each left-channel sample to 24 bits and writes it sequentially into the single-port sample RAM (14-bit address, 24-bit data).
- The playback path later reads that RAM. One take is at most DEPTH samples; the block raises done when the take ends.

Parameters:
- DEPTH, 15000, samples per take; the last address written is DEPTH-1.
- ADDR_W, 14, RAM address width.
- DATA_W, 24, RAM word width; the stored word is left_channel_audio_in[31:32-DATA_W].
- THRESHOLD, 24'h080000, trigger magnitude; used only when RECORD_TRIGGER_EN is defined.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a take.
- stop  in  1  single-cycle pulse; ends a take early.
- audio_in_available  in  1  Audio_Controller has an input sample.
- left_channel_audio_in  in  32  sample from Audio_Controller, valid while available is high.
- read_audio_in  out  1  single-cycle pop pulse to Audio_Controller.
- ram_address  out  ADDR_W  RAM write address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable, single-cycle pulse.
- recording  out  1  high while in RECORD.
- done  out  1  high in DONE; cleared by start.
- sample_count  out  ADDR_W  number of samples written in the current take.

Behaviour:
- Reset (asynchronous, resetn low): state=IDLE; all outputs 0; write pointer 0; any pending write is discarded.
- Pop rule, applies in every state:
  - read_audio_in is a registered pulse. It goes high the cycle after audio_in_available is seen high, provided read_audio_in was low in the previous cycle.
  - As a result it is never high two cycles in a row, and the controller FIFO is always drained, so the input never stalls.
- Capture:
  - In RECORD, the cycle read_audio_in is high, the block latches left_channel_audio_in[31:8].
  - On the next cycle it drives ram_wren=1, ram_address=wr_ptr, ram_data=latched word.
  - Latency from pop pulse to write is exactly 1 cycle.
  - wr_ptr and sample_count increment in the write cycle.
  - ram_address holds its value between writes.
- States:
  - IDLE: start goes to RECORD with wr_ptr=0 and sample_count=0. stop is ignored. If start and stop arrive together, start wins.
  - RECORD:
    - A write to address DEPTH-1 goes to DONE in the same cycle; the pointer does not wrap and sample_count=DEPTH.
    - stop goes to DONE. If a capture is pending (pop seen last cycle), its write still completes in the transition cycle.
    - start is ignored. If start and stop arrive together, stop wins.
  - DONE: done=1 and no writes occur. start clears done, resets wr_ptr and sample_count to 0, and enters RECORD. stop is ignored.
- If a pop occurs in the same cycle as entering RECORD, that sample is not captured. The first captured sample is from the next pop.
- recording is a registered decode of RECORD; done is a registered decode of DONE.

Optional Feature:
- Macro RECORD_TRIGGER_EN.
- Defined:
  - start enters ARMED instead of RECORD.
  - In ARMED, each popped sample is compared as signed 24-bit magnitude. |sample| >= THRESHOLD enters RECORD, and that same sample is written to address 0.
  - stop in ARMED enters DONE with sample_count=0.
  - recording stays 0 in ARMED.
- Undefined: the ARMED state and the comparator are absent, and THRESHOLD is unused.

Decomposition:
- Package audio_rec_pkg holds:
  - the state enum (IDLE, ARMED, RECORD, DONE);
  - the constants DEPTH, ADDR_W, DATA_W;
  - a function for the signed 24-bit magnitude.
- One sub-module, audio_pop_ctrl, implements the read_audio_in pulse generator and sample latch. It is reused by future analysis blocks.

Test Plan:
1. resetn low for 3 cycles while available=1 -> all outputs 0. After release, the first read_audio_in pulse appears 1 cycle after available is sampled.
2. start, then 5 pops with samples 0x12345600, 0xFFFFFF00, 0x00000100, 0x7FFFFF00, 0x80000000 -> writes at addresses 0..4 with data 0x123456, 0xFFFFFF, 0x000001, 0x7FFFFF, 0x800000; each ram_wren is 1 cycle after its pop; sample_count=5.
3. start, then 15000 pops -> the last write is to address 14999, done=1 the following cycle, sample_count=15000. Pop 15001 gives no ram_wren.
4. stop asserted in the same cycle as a pop in RECORD -> that sample is still written, then DONE. start and stop together in RECORD -> stop wins.
5. done=1, then start -> done clears, the next write is to address 0, and sample_count restarts at 1.
6. (RECORD_TRIGGER_EN) start, then samples 0x07FFFF00, 0xF8000100 -> no writes (both magnitudes below THRESHOLD). Next sample 0xF8000000 (magnitude 0x080000) -> written at address 0, recording=1.

Source files
------------

// File: rtl/audio_rec_pkg.sv
// audio_rec_pkg: shared types and constants for the capture path.
// Optional trigger feature: RECORD_TRIGGER_EN (see audio_recorder).
package audio_rec_pkg;

    localparam int DEPTH  = 15000;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RECORD,
        DONE
    } rec_state_e;

    // Magnitude of a two's-complement sample; 0x800000 maps to 0x800000.
    function automatic logic [DATA_W-1:0] mag24(
        input logic [DATA_W-1:0] s
    );
        mag24 = s[DATA_W-1] ? (~s + DATA_W'(1)) : s;
    endfunction

endpackage

// File: rtl/audio_pop_ctrl.sv
// audio_pop_ctrl: pop pulse generator and sample latch for Audio_Controller.
// Keeps the controller FIFO drained; shared with analysis blocks.
module audio_pop_ctrl
    import audio_rec_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              available,
    input  logic [31:0]       audio_in,
    output logic              read_pulse,
    output logic [DATA_W-1:0] sample
);

    logic unused_lsb;

    assign unused_lsb = ^audio_in[31-DATA_W:0];

    // Pop on every available sample, never two cycles in a row; latch on pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            read_pulse <= 1'b0;
            sample     <= '0;
        end else begin
            read_pulse <= available && !read_pulse;
            if (read_pulse) begin
                sample <= audio_in[31:32-DATA_W];
            end
        end
    end

endmodule

// File: rtl/audio_recorder.sv
// audio_recorder: drains mic samples and writes one take into sample RAM.
// Define RECORD_TRIGGER_EN to wait in ARMED for a loud sample before recording.
module audio_recorder
    import audio_rec_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    output logic              read_audio_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W-1:0] sample_count
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

`ifdef RECORD_TRIGGER_EN
    localparam logic [DATA_W-1:0] THRESHOLD = 24'h080000;
    localparam rec_state_e TAKE_ST = ARMED;
`else
    localparam rec_state_e TAKE_ST = RECORD;
`endif

    rec_state_e        state;
    rec_state_e        state_nx;
    logic              wr_pend;
    logic              cap_go;
    logic              new_take;
    logic [ADDR_W-1:0] wr_ptr;

`ifdef RECORD_TRIGGER_EN
    logic trig_hit;

    assign trig_hit = read_audio_in &&
        (mag24(left_channel_audio_in[31:32-DATA_W]) >= THRESHOLD);
`endif

    audio_pop_ctrl u_pop (
        .clk        (CLOCK_50),
        .resetn     (resetn),
        .available  (audio_in_available),
        .audio_in   (left_channel_audio_in),
        .read_pulse (read_audio_in),
        .sample     (ram_data)
    );

    assign ram_wren     = wr_pend;
    assign sample_count = wr_ptr;

    // Next state, capture decision and take restart.
    always_comb begin
        state_nx = state;
        cap_go   = 1'b0;
        new_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = TAKE_ST;
                    new_take = 1'b1;
                end
            end
            ARMED: begin
`ifdef RECORD_TRIGGER_EN
                if (stop) begin
                    state_nx = DONE;
                end else if (trig_hit) begin
                    state_nx = RECORD;
                    cap_go   = 1'b1;
                end
`else
                state_nx = IDLE;
`endif
            end
            RECORD: begin
                // a pop seen with stop is still written, one cycle later
                cap_go = read_audio_in;
                if (stop || (wr_pend && wr_ptr == LAST)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = TAKE_ST;
                    new_take = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register with registered status decodes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            recording <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            recording <= (state_nx == RECORD);
            done      <= (state_nx == DONE);
        end
    end

    // Write pipeline: address captured on pop, write and count one cycle later.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_pend     <= 1'b0;
            wr_ptr      <= '0;
            ram_address <= '0;
        end else begin
            wr_pend <= cap_go;
            if (cap_go) begin
                ram_address <= wr_ptr;
            end
            if (new_take) begin
                wr_ptr <= '0;
            end else if (wr_pend) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_recorder.sv
// tb_audio_recorder: table-driven pops with a write scoreboard for audio_recorder.
// Trigger checks run only when RECORD_TRIGGER_EN is defined.
module tb_audio_recorder;

    logic        CLOCK_50;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        audio_in_available;
    logic [31:0] left_channel_audio_in;
    logic        read_audio_in;
    logic [13:0] ram_address;
    logic [23:0] ram_data;
    logic        ram_wren;
    logic        recording;
    logic        done;
    logic [13:0] sample_count;

    typedef struct {
        logic [31:0] sample;
        logic [23:0] exp_data;
    } vec_t;

    typedef struct {
        logic [13:0] addr;
        logic [23:0] data;
    } wr_t;

    vec_t tbl[5];
    wr_t  sb[$];
    wr_t  mon_e;
    int   vectors;
    int   miscompares;
    int   exp_addr;

    audio_recorder dut (
        .CLOCK_50              (CLOCK_50),
        .resetn                (resetn),
        .start                 (start),
        .stop                  (stop),
        .audio_in_available    (audio_in_available),
        .left_channel_audio_in (left_channel_audio_in),
        .read_audio_in         (read_audio_in),
        .ram_address           (ram_address),
        .ram_data              (ram_data),
        .ram_wren              (ram_wren),
        .recording             (recording),
        .done                  (done),
        .sample_count          (sample_count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic void check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One pop: available for one cycle, pulse one cycle later, write after that.
    task automatic do_pop(
        input logic [31:0] s,
        input bit          cap,
        input logic [23:0] d,
        input bit          stop_at_pop
    );
        audio_in_available    = 1'b1;
        left_channel_audio_in = s;
        tick();
        check("pop_pulse", 32'(read_audio_in), 32'd1);
        check("wren_early", 32'(ram_wren), 32'd0);
        audio_in_available = 1'b0;
        stop = stop_at_pop;
        if (cap) begin
            sb.push_back('{addr: 14'(exp_addr), data: d});
            exp_addr++;
        end
        tick();
        stop = 1'b0;
        check("pop_low", 32'(read_audio_in), 32'd0);
        check("wren_lat", 32'(ram_wren), cap ? 32'd1 : 32'd0);
        if (stop_at_pop) begin
            check("stop_done", 32'(done), 32'd1);
        end
    endtask

    task automatic pulse(input logic st, input logic sp);
        start = st;
        stop  = sp;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Every RAM write must match the oldest expected write.
    always @(negedge CLOCK_50) begin
        if (ram_wren) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data %h, want none",
                    ram_address, ram_data);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(ram_address), 32'(mon_e.addr));
                check("wr_data", 32'(ram_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_addr    = 0;
        tbl[0] = '{32'h12345600, 24'h123456};
        tbl[1] = '{32'hFFFFFF00, 24'hFFFFFF};
        tbl[2] = '{32'h00000100, 24'h000001};
        tbl[3] = '{32'h7FFFFF00, 24'h7FFFFF};
        tbl[4] = '{32'h80000000, 24'h800000};

        // reset with available held high
        resetn                = 1'b0;
        start                 = 1'b0;
        stop                  = 1'b0;
        audio_in_available    = 1'b1;
        left_channel_audio_in = 32'hA5A5A500;
        repeat (3) tick();
        check("rst_read", 32'(read_audio_in), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        check("rst_rec", 32'(recording), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(sample_count), 32'd0);
        resetn = 1'b1;
        tick();
        check("first_pop", 32'(read_audio_in), 32'd1);
        audio_in_available = 1'b0;
        tick();
        check("idle_wren", 32'(ram_wren), 32'd0);
        check("idle_pop_low", 32'(read_audio_in), 32'd0);

        // start+stop in IDLE: start wins; five table samples
        pulse(1'b1, 1'b1);
        check("t2_done", 32'(done), 32'd0);
`ifndef RECORD_TRIGGER_EN
        check("t2_rec", 32'(recording), 32'd1);
`endif
        exp_addr = 0;
        for (int i = 0; i < 5; i++) begin
            do_pop(tbl[i].sample, 1'b1, tbl[i].exp_data, 1'b0);
        end
        tick();
        check("t2_cnt", 32'(sample_count), 32'd5);
        pulse(1'b0, 1'b1);
        check("t2_stop_done", 32'(done), 32'd1);
        check("t2_stop_rec", 32'(recording), 32'd0);

        // full take
        pulse(1'b1, 1'b0);
        exp_addr = 0;
        for (int i = 0; i < 15000; i++) begin
            do_pop({24'h400000 + 24'(i), 8'h00}, 1'b1,
                24'h400000 + 24'(i), 1'b0);
        end
        tick();
        check("t3_done", 32'(done), 32'd1);
        check("t3_cnt", 32'(sample_count), 32'd15000);
        do_pop(32'h44444400, 1'b0, 24'h0, 1'b0);
        check("t3_cnt_hold", 32'(sample_count), 32'd15000);

        // restart from DONE
        pulse(1'b1, 1'b0);
        check("t5_done_clr", 32'(done), 32'd0);
        check("t5_cnt0", 32'(sample_count), 32'd0);
        exp_addr = 0;
        do_pop(32'h55AA3300, 1'b1, 24'h55AA33, 1'b0);
        tick();
        check("t5_cnt1", 32'(sample_count), 32'd1);

        // stop in the pop cycle: sample still written
        do_pop(32'h66778800, 1'b1, 24'h667788, 1'b1);
        tick();
        check("t4_cnt", 32'(sample_count), 32'd2);
        check("t4_done", 32'(done), 32'd1);

        // start+stop in RECORD: stop wins
        pulse(1'b1, 1'b0);
        exp_addr = 0;
        do_pop(32'h61000000, 1'b1, 24'h610000, 1'b0);
        tick();
        pulse(1'b1, 1'b1);
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_cnt", 32'(sample_count), 32'd1);
        do_pop(32'h62000000, 1'b0, 24'h0, 1'b0);

`ifdef RECORD_TRIGGER_EN
        // trigger: two sub-threshold samples, then one at threshold
        pulse(1'b1, 1'b0);
        check("t6_armed_rec", 32'(recording), 32'd0);
        do_pop(32'h07FFFF00, 1'b0, 24'h0, 1'b0);
        do_pop(32'hF8000100, 1'b0, 24'h0, 1'b0);
        check("t6_still_armed", 32'(recording), 32'd0);
        exp_addr = 0;
        do_pop(32'hF8000000, 1'b1, 24'hF80000, 1'b0);
        check("t6_rec", 32'(recording), 32'd1);
        tick();
        check("t6_cnt", 32'(sample_count), 32'd1);
`endif

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule
